// File: rtl/clkdiv_ratio_ctrl.sv
// Configuration sequencer for the UART bit-rate clock divider: owns the divider enable and ratio,
// and applies every ratio change as gate -> load -> settle -> re-enable.
module clkdiv_ratio_ctrl #(
    parameter int unsigned RATIO_WD   = 4,
    parameter int unsigned GATE_CYC   = 2,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned DEF_RATIO  = 4
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_cfg_valid,
    input  logic [RATIO_WD-1:0] i_cfg_ratio,
    output logic                o_cfg_ready,
    input  logic [5:0]          i_prescale,
    output logic                o_clk_en,
    output logic [RATIO_WD-1:0] o_div_ratio,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    typedef enum logic [1:0] {
        StIdle,
        StGate,
        StLoad,
        StSettle
    } state_e;

    localparam logic [RATIO_WD-1:0] DefRatio   = RATIO_WD'(DEF_RATIO);
    localparam logic [3:0]          GateLast   = 4'(GATE_CYC - 1);
    localparam logic [3:0]          SettleLast = 4'(SETTLE_CYC - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [RATIO_WD-1:0] pending_q, pending_d;
    logic [RATIO_WD-1:0] div_ratio_q, div_ratio_d;
    logic [5:0]          prescale_q, prescale_d;
    logic                clk_en_q, clk_en_d;
    logic                err_q, err_d;

    logic                presc_chg;
    logic                presc_legal;
    logic [RATIO_WD-1:0] presc_ratio;

    assign presc_chg = (i_prescale != prescale_q);

    always_comb begin
        presc_legal = 1'b1;
        presc_ratio = DefRatio;
        case (i_prescale)
            6'd32:   presc_ratio = RATIO_WD'(1);
            6'd16:   presc_ratio = RATIO_WD'(2);
            6'd8:    presc_ratio = RATIO_WD'(4);
            default: begin
                presc_legal = 1'b0;
                presc_ratio = '0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        div_ratio_d = div_ratio_q;
        prescale_d  = prescale_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An explicit request beats a prescale change; prescale_q is left alone so the
                // change is re-detected once the controller is idle again.
                if (i_cfg_valid) begin
                    if (i_cfg_ratio != div_ratio_q) begin
                        pending_d = i_cfg_ratio;
                        cnt_d     = '0;
                        state_d   = StGate;
                    end
                end else if (presc_chg) begin
                    prescale_d = i_prescale;
                    if (presc_legal) begin
                        if (presc_ratio != div_ratio_q) begin
                            pending_d = presc_ratio;
                            cnt_d     = '0;
                            state_d   = StGate;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGate: begin
                if (cnt_q == GateLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StLoad: begin
                div_ratio_d = pending_q;
                cnt_d       = '0;
                state_d     = StSettle;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        // Enable is only granted when the controller will be idle, so ratio and enable never
        // move together.
        clk_en_d = (state_d == StIdle) & i_en;
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pending_q   <= DefRatio;
            div_ratio_q <= DefRatio;
            prescale_q  <= '0;
            clk_en_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            div_ratio_q <= div_ratio_d;
            prescale_q  <= prescale_d;
            clk_en_q    <= clk_en_d;
            err_q       <= err_d;
        end
    end

    assign o_clk_en    = clk_en_q;
    assign o_div_ratio = div_ratio_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != StIdle);
    assign o_cfg_ready = (state_q == StIdle);
    assign o_done      = (state_q == StSettle) && (cnt_q == SettleLast);

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Bench for clkdiv_ratio_ctrl: directed scenarios plus random traffic, checked every cycle against
// a timeline model that tracks how many cycles have elapsed since a change was accepted.
module tb_clkdiv_ratio_ctrl;

    localparam int G   = 2;
    localparam int S   = 2;
    localparam int DEF = 4;

    logic       clk;
    logic       i_rst;
    logic       i_en;
    logic       i_cfg_valid;
    logic [3:0] i_cfg_ratio;
    logic [5:0] i_prescale;
    logic       o_cfg_ready;
    logic       o_clk_en;
    logic [3:0] o_div_ratio;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    clkdiv_ratio_ctrl #(
        .RATIO_WD  (4),
        .GATE_CYC  (G),
        .SETTLE_CYC(S),
        .DEF_RATIO (DEF)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_ratio(i_cfg_ratio),
        .o_cfg_ready(o_cfg_ready),
        .i_prescale (i_prescale),
        .o_clk_en   (o_clk_en),
        .o_div_ratio(o_div_ratio),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;

    // Model: m_k = cycles since acceptance (0 = idle; 1..G+S+1 = sequence in flight).
    int         m_k;
    logic [3:0] m_ratio;
    logic [3:0] m_pend;
    logic [5:0] m_presc;
    bit         m_clk_en;
    bit         m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int map_presc(input logic [5:0] p);
        case (p)
            6'd32:   return 1;
            6'd16:   return 2;
            6'd8:    return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_ratio  = 4'(DEF);
        m_pend   = 4'(DEF);
        m_presc  = '0;
        m_clk_en = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit v, input logic [3:0] r,
                              input logic [5:0] p);
        int mp;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (m_k == 0) begin
            if (v) begin
                if (r != m_ratio) begin
                    m_pend = r;
                    m_k    = 1;
                end
            end else if (p != m_presc) begin
                m_presc = p;
                mp      = map_presc(p);
                if (mp < 0) m_err = 1'b1;
                else if (mp != int'(m_ratio)) begin
                    m_pend = 4'(mp);
                    m_k    = 1;
                end
            end
        end else begin
            if (m_k == G + 1) m_ratio = m_pend;
            m_k = (m_k == G + S + 1) ? 0 : m_k + 1;
        end
        m_clk_en = (m_k == 0) && en;
    endtask

    task automatic check_outputs();
        if (o_done === 1'b1) n_done++;
        if (o_err === 1'b1) n_err++;
        check_val("clk_en", 32'(o_clk_en), 32'(m_clk_en));
        check_val("div_ratio", 32'(o_div_ratio), 32'(m_ratio));
        check_val("busy", 32'(o_busy), 32'(m_k != 0));
        check_val("cfg_ready", 32'(o_cfg_ready), 32'(m_k == 0));
        check_val("done", 32'(o_done), 32'(m_k == G + S + 1));
        check_val("err", 32'(o_err), 32'(m_err));
    endtask

    // Check the cycle that is ending, then present new inputs for the next edge.
    task automatic step(input bit rst, input bit en, input bit v, input logic [3:0] r,
                        input logic [5:0] p);
        @(negedge clk);
        check_outputs();
        i_rst       = rst;
        i_en        = en;
        i_cfg_valid = v;
        i_cfg_ratio = r;
        i_prescale  = p;
        model_step(rst, en, v, r, p);
    endtask

    initial begin
        int         d0;
        int         e0;
        logic [5:0] cur_p;
        logic [5:0] legal_p [3];
        legal_p[0] = 6'd8;
        legal_p[1] = 6'd16;
        legal_p[2] = 6'd32;

        i_rst       = 1'b1;
        i_en        = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_ratio = '0;
        i_prescale  = 6'd8;
        model_reset();

        // Reset release with prescale 8 maps to the default ratio: no sequence.
        step(1, 1, 0, 0, 8);
        step(1, 1, 0, 0, 8);
        d0 = n_done;
        step(0, 1, 0, 0, 8);
        repeat (6) step(0, 1, 0, 0, 8);
        check_val("t1_no_done", 32'(n_done - d0), 32'd0);
        check_val("t1_clk_en", 32'(o_clk_en), 32'd1);

        // Explicit change to 6.
        step(0, 1, 1, 6, 8);
        repeat (8) step(0, 1, 0, 0, 8);
        check_val("t2_ratio", 32'(o_div_ratio), 32'd6);

        // Config and prescale change in the same cycle: two sequences.
        d0 = n_done;
        step(0, 1, 1, 3, 32);
        repeat (16) step(0, 1, 0, 0, 32);
        check_val("t3_done_cnt", 32'(n_done - d0), 32'd2);
        check_val("t3_ratio", 32'(o_div_ratio), 32'd1);

        // Illegal prescale code: single error pulse.
        e0 = n_err;
        repeat (6) step(0, 1, 0, 0, 20);
        check_val("t4_err_cnt", 32'(n_err - e0), 32'd1);
        check_val("t4_ratio", 32'(o_div_ratio), 32'd1);

        // Reset in the middle of a change to 7.
        step(0, 1, 1, 7, 20);
        repeat (4) step(0, 1, 0, 0, 20);
        step(1, 1, 0, 0, 16);
        #1;
        check_val("t5_rst_ratio", 32'(o_div_ratio), 32'(DEF));
        check_val("t5_rst_clk_en", 32'(o_clk_en), 32'd0);
        check_val("t5_rst_busy", 32'(o_busy), 32'd0);
        step(0, 1, 0, 0, 16);
        repeat (10) step(0, 1, 0, 0, 16);
        check_val("t5_ratio", 32'(o_div_ratio), 32'd2);

        // Request held across a sequence.
        step(0, 1, 1, 9, 16);
        step(0, 1, 1, 9, 16);
        repeat (10) step(0, 0, 1, 5, 16);
        repeat (8) step(0, 1, 0, 0, 16);
        check_val("t6_ratio", 32'(o_div_ratio), 32'd5);

        // Random traffic.
        cur_p = 6'd16;
        for (int i = 0; i < 3000; i++) begin
            bit         rst;
            bit         en;
            bit         v;
            logic [3:0] r;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 7) == 0);
            r   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) cur_p = 6'($urandom_range(0, 63));
                else cur_p = legal_p[$urandom_range(0, 2)];
            end
            step(rst, en, v, r, cur_p);
        end
        step(0, 1, 0, 0, cur_p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
